// File: rtl/sdp_block_ram.sv
// Simple dual-port RAM (1 write, 1 read, common clock) with per-lane write enables and selectable collision policy.
// Read latency 1 cycle; no backpressure, one read and one write are accepted every cycle.
module sdp_block_ram #(
    parameter int    DATA_WIDTH        = 32,
    parameter int    SIZE              = 1024,
    parameter int    ADDR_WIDTH        = $clog2(SIZE),
    parameter int    BYTE_WRITE_WIDTH  = DATA_WIDTH,
    parameter string READ_DURING_WRITE = "NEW_DATA"
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     read_en,
    input  logic [ADDR_WIDTH-1:0]                    read_addr,
    output logic [DATA_WIDTH-1:0]                    read_data,
    input  logic                                     write_en,
    input  logic [DATA_WIDTH/BYTE_WRITE_WIDTH-1:0]   write_lane_en,
    input  logic [ADDR_WIDTH-1:0]                    write_addr,
    input  logic [DATA_WIDTH-1:0]                    write_data
);

    localparam int                NUM_LANES = DATA_WIDTH / BYTE_WRITE_WIDTH;
    localparam bit                LP_BYPASS = (READ_DURING_WRITE == "NEW_DATA");
    localparam logic [ADDR_WIDTH:0] LP_SIZE = (ADDR_WIDTH + 1)'(SIZE);

    logic [DATA_WIDTH-1:0] r_mem [SIZE] = '{default: '0};

    logic [DATA_WIDTH-1:0] r_arr_dat;
    logic                  r_byp_en;
    logic [NUM_LANES-1:0]  r_byp_mask;
    logic [DATA_WIDTH-1:0] r_byp_dat;

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_rd_dat;

    // Addresses past SIZE only exist when SIZE is not a power of two.
    assign w_rd_ok   = ({1'b0, read_addr} < LP_SIZE);
    assign w_wr_ok   = ({1'b0, write_addr} < LP_SIZE);
    assign w_collide = LP_BYPASS && read_en && write_en && w_wr_ok && (read_addr == write_addr);

    always_ff @(posedge clk) begin
        if (write_en && w_wr_ok) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (write_lane_en[i]) begin
                    r_mem[write_addr][i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] <=
                        write_data[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
                end
            end
        end
    end

    // The array itself always returns old data; new data is merged in after the register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arr_dat <= '0;
            r_byp_en  <= 1'b0;
        end else if (read_en) begin
            r_arr_dat <= w_rd_ok ? r_mem[read_addr] : '0;
            r_byp_en  <= w_collide;
        end
    end

    always_ff @(posedge clk) begin
        if (read_en) begin
            r_byp_mask <= write_lane_en;
            r_byp_dat  <= write_data;
        end
    end

    always_comb begin
        w_rd_dat = r_arr_dat;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_byp_en && r_byp_mask[i]) begin
                w_rd_dat[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] =
                    r_byp_dat[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
            end
        end
    end

    assign read_data = w_rd_dat;

endmodule

// File: tb/tb_sdp_block_ram.sv
// Directed bench for sdp_block_ram: NEW_DATA and OLD_DATA instances with 8-bit lanes
// share stimulus; a SIZE=100 instance covers out-of-range addressing.
module tb_sdp_block_ram;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        re = 1'b0;
    logic [9:0]  raddr = '0;
    logic        we = 1'b0;
    logic [3:0]  lane = '0;
    logic [9:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rd_new;
    logic [31:0] rd_old;

    logic        s_re = 1'b0;
    logic [6:0]  s_raddr = '0;
    logic        s_we = 1'b0;
    logic [0:0]  s_lane = 1'b1;
    logic [6:0]  s_waddr = '0;
    logic [31:0] s_wdata = '0;
    logic [31:0] rd_small;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdp_block_ram #(
        .DATA_WIDTH(32), .SIZE(1024), .BYTE_WRITE_WIDTH(8), .READ_DURING_WRITE("NEW_DATA")
    ) dut_new (
        .clk(clk), .reset(reset), .read_en(re), .read_addr(raddr), .read_data(rd_new),
        .write_en(we), .write_lane_en(lane), .write_addr(waddr), .write_data(wdata)
    );

    sdp_block_ram #(
        .DATA_WIDTH(32), .SIZE(1024), .BYTE_WRITE_WIDTH(8), .READ_DURING_WRITE("OLD_DATA")
    ) dut_old (
        .clk(clk), .reset(reset), .read_en(re), .read_addr(raddr), .read_data(rd_old),
        .write_en(we), .write_lane_en(lane), .write_addr(waddr), .write_data(wdata)
    );

    sdp_block_ram #(
        .DATA_WIDTH(32), .SIZE(100)
    ) dut_small (
        .clk(clk), .reset(reset), .read_en(s_re), .read_addr(s_raddr), .read_data(rd_small),
        .write_en(s_we), .write_lane_en(s_lane), .write_addr(s_waddr), .write_data(s_wdata)
    );

    typedef struct {
        logic        we;
        logic [3:0]  lane;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic        re;
        logic [9:0]  raddr;
        logic [31:0] exp_new;
        logic [31:0] exp_old;
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we_i, input logic [3:0] lane_i, input logic [9:0] waddr_i,
                         input logic [31:0] wdata_i, input logic re_i, input logic [9:0] raddr_i);
        @(negedge clk);
        we    = we_i;
        lane  = lane_i;
        waddr = waddr_i;
        wdata = wdata_i;
        re    = re_i;
        raddr = raddr_i;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic we_i, input logic [6:0] waddr_i, input logic [31:0] wdata_i,
                           input logic re_i, input logic [6:0] raddr_i);
        @(negedge clk);
        s_we    = we_i;
        s_waddr = waddr_i;
        s_wdata = wdata_i;
        s_re    = re_i;
        s_raddr = raddr_i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         we    lane   waddr  wdata          re    raddr  exp_new        exp_old
        vt[0]  = '{1'b1, 4'hF,  10'd5, 32'hDEADBEEF, 1'b0, 10'd0,  32'h00000000, 32'h00000000};
        vt[1]  = '{1'b0, 4'hF,  10'd0, 32'h00000000, 1'b1, 10'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[2]  = '{1'b0, 4'hF,  10'd0, 32'h00000000, 1'b1, 10'd6,  32'h00000000, 32'h00000000};
        vt[3]  = '{1'b0, 4'hF,  10'd0, 32'h00000000, 1'b1, 10'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[4]  = '{1'b0, 4'hF,  10'd0, 32'h00000000, 1'b0, 10'd6,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[5]  = '{1'b1, 4'hF,  10'd9, 32'h11223344, 1'b0, 10'd6,  32'hDEADBEEF, 32'hDEADBEEF};
        vt[6]  = '{1'b1, 4'h5,  10'd9, 32'hAABBCCDD, 1'b1, 10'd9,  32'h11BB33DD, 32'h11223344};
        vt[7]  = '{1'b0, 4'h0,  10'd0, 32'h00000000, 1'b1, 10'd9,  32'h11BB33DD, 32'h11BB33DD};
        vt[8]  = '{1'b0, 4'h0,  10'd0, 32'h00000000, 1'b0, 10'd3,  32'h11BB33DD, 32'h11BB33DD};
        vt[9]  = '{1'b1, 4'hF,  10'd9, 32'h55667788, 1'b1, 10'd9,  32'h55667788, 32'h11BB33DD};
        vt[10] = '{1'b1, 4'h0,  10'd9, 32'hFFFFFFFF, 1'b1, 10'd9,  32'h55667788, 32'h55667788};
        vt[11] = '{1'b0, 4'hF,  10'd9, 32'h00000000, 1'b1, 10'd9,  32'h55667788, 32'h55667788};
        vt[12] = '{1'b1, 4'hF, 10'd10, 32'h0A0A0A0A, 1'b1, 10'd9,  32'h55667788, 32'h55667788};
        vt[13] = '{1'b0, 4'h0,  10'd0, 32'h00000000, 1'b1, 10'd10, 32'h0A0A0A0A, 32'h0A0A0A0A};

        // Reset state: reads are ignored while reset is high.
        re    = 1'b1;
        raddr = 10'd5;
        s_re  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_new", rd_new, 32'h0);
        check("reset_old", rd_old, 32'h0);
        check("reset_small", rd_small, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        re    = 1'b0;
        s_re  = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].we, vt[i].lane, vt[i].waddr, vt[i].wdata, vt[i].re, vt[i].raddr);
            check($sformatf("vec%0d_new", i), rd_new, vt[i].exp_new);
            check($sformatf("vec%0d_old", i), rd_old, vt[i].exp_old);
        end

        // Streaming: write a while reading a-1 on every edge.
        for (int a = 0; a <= 1024; a++) begin
            drive(a < 1024, 4'hF, 10'(a), 32'(a * 3), a >= 1, 10'(a - 1));
            if (a >= 1) begin
                check($sformatf("stream%0d_new", a - 1), rd_new, 32'((a - 1) * 3));
                check($sformatf("stream%0d_old", a - 1), rd_old, 32'((a - 1) * 3));
            end
        end
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        check("stream_after_new", rd_new, 32'd15);
        check("stream_after_old", rd_old, 32'd15);

        // Collision leaves the bypass armed on the NEW_DATA instance before reset hits.
        drive(1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b1, 10'd5);
        check("pre_reset_new", rd_new, 32'hDEADBEEF);
        check("pre_reset_old", rd_old, 32'd15);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_new", rd_new, 32'h0);
        check("async_reset_old", rd_old, 32'h0);
        drive(1'b1, 4'hF, 10'd7, 32'h77777777, 1'b1, 10'd5);
        check("in_reset_new", rd_new, 32'h0);
        check("in_reset_old", rd_old, 32'h0);
        reset = 1'b0;
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
        check("post_reset_new", rd_new, 32'hDEADBEEF);
        check("post_reset_old", rd_old, 32'hDEADBEEF);
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd7);
        check("reset_write_new", rd_new, 32'h77777777);
        check("reset_write_old", rd_old, 32'h77777777);
        drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);

        // Non-power-of-two depth.
        drive_s(1'b1, 7'd120, 32'h12345678, 1'b0, 7'd0);
        drive_s(1'b0, 7'd0, 32'h0, 1'b1, 7'd120);
        check("oor_read", rd_small, 32'h0);
        drive_s(1'b1, 7'd99, 32'hCAFEF00D, 1'b1, 7'd20);
        check("oor_alias20", rd_small, 32'h0);
        drive_s(1'b0, 7'd0, 32'h0, 1'b1, 7'd99);
        check("last_word", rd_small, 32'hCAFEF00D);
        drive_s(1'b0, 7'd0, 32'h0, 1'b1, 7'd56);
        check("oor_alias56", rd_small, 32'h0);
        drive_s(1'b1, 7'd99, 32'h0BADC0DE, 1'b1, 7'd120);
        check("oor_read_again", rd_small, 32'h0);
        drive_s(1'b1, 7'd120, 32'h87654321, 1'b1, 7'd120);
        check("oor_collide", rd_small, 32'h0);
        drive_s(1'b0, 7'd0, 32'h0, 1'b1, 7'd99);
        check("last_word_rewrite", rd_small, 32'h0BADC0DE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
